// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side connection bundle for the EX-stage multiply/divide unit.
// The pipeline drives the master side; the unit itself is the slave.
interface ex_muldiv_unit_if #(
    parameter int W = 32
);
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         cancel;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         stall_req;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        input  stall_req, busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        output stall_req, busy, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one product/quotient bit per
// cycle on unsigned magnitudes, with sign correction applied in the DONE cycle.
module ex_muldiv_unit #(
    parameter  int W     = 32,
    localparam int CNT_W = $clog2(W) + 1
) (
    input logic             clk,
    input logic             rst,
    ex_muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_dz;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [W-1:0]     r_src_a;
    logic [W-1:0]     r_opnd;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_start;
    logic             w_last;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_next;
    logic [W:0]       w_trial;
    logic [2*W-1:0]   w_div_next;
    logic [2*W-1:0]   w_prod;
    logic [W-1:0]     w_quot;
    logic [W-1:0]     w_rem;

    assign w_start  = (r_state == S_IDLE) && bus.start && !bus.cancel;
    assign w_last   = (r_cnt == CNT_W'(W - 1));
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.src_a[W-1];
    assign w_b_neg  = w_signed & bus.src_b[W-1];
    assign w_a_mag  = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_b_mag  = w_b_neg ? -bus.src_b : bus.src_b;

    // Multiply: r_acc = {partial product, unconsumed multiplier bits}.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
    assign w_trial    = r_acc[2*W-1:W-1] - {1'b0, r_opnd};
    assign w_div_next = w_trial[W] ? {r_acc[2*W-2:0], 1'b0}
                                   : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = bus.op[1] ? S_DIV : S_MUL;
            S_MUL,
            S_DIV: begin
                if (bus.cancel)  w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every read sees pre-edge values.
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_src_a  <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (w_start) begin
                        r_cnt    <= '0;
                        r_is_div <= bus.op[1];
                        r_dz     <= bus.op[1] && (bus.src_b == '0);
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_src_a  <= bus.src_a;
                        r_opnd   <= bus.op[1] ? w_b_mag : w_a_mag;
                        r_acc    <= {{W{1'b0}}, bus.op[1] ? w_a_mag : w_b_mag};
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    if (!bus.cancel) begin
                        if (r_dz) begin
                            r_hi <= r_src_a;
                            r_lo <= '1;
                        end else if (r_is_div) begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.stall_req = w_start || (r_state == S_MUL) || (r_state == S_DIV);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE) && !bus.cancel;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit at W=32 and W=8: stimulus pushes model
// results into queues, monitors pop and compare on each done pulse.
module tb_ex_muldiv_unit;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        q32[$];
    exp_t        q8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_unit_if #(.W(32)) if32();
    ex_muldiv_unit_if #(.W(8))  if8();

    ex_muldiv_unit #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    ex_muldiv_unit #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on sign-interpreted operands.
    function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] hi,
                                  output logic [63:0] lo);
        longint      sa, sb;
        logic [63:0] mask, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        p = '0; q = '0; r = '0;
        if (op[1]) begin
            if (b == 64'd0) begin
                hi = a;
                lo = mask;
            end else begin
                if (op == 2'b10) begin
                    q = 64'(sa / sb);
                    r = 64'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                hi = r & mask;
                lo = q & mask;
            end
        end else begin
            p  = (op == 2'b00) ? 64'(sa * sb) : a * b;
            hi = (p >> w) & mask;
            lo = p & mask;
        end
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = 64'd0;
            1:       v = 64'd1;
            2:       v = '1;
            3:       v = 64'd1 << (w - 1);
            4:       v = (64'd1 << (w - 1)) - 64'd1;
            5:       v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & ((64'd1 << w) - 64'd1);
    endfunction

    always begin
        exp_t        e;
        int unsigned dc;
        @(negedge clk);
        if (!rst && if32.done) begin
            dc = cyc;
            if (q32.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done32: done seen at cycle %0d, none expected", dc);
            end else begin
                e = q32.pop_front();
                check("latency32", 64'(dc - e.cyc), 64'd33);
                @(negedge clk);
                check("hi32", 64'(if32.hi), e.hi);
                check("lo32", 64'(if32.lo), e.lo);
            end
        end
    end

    always begin
        exp_t        e;
        int unsigned dc;
        @(negedge clk);
        if (!rst && if8.done) begin
            dc = cyc;
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done8: done seen at cycle %0d, none expected", dc);
            end else begin
                e = q8.pop_front();
                check("latency8", 64'(dc - e.cyc), 64'd9);
                @(negedge clk);
                check("hi8", 64'(if8.hi), e.hi);
                check("lo8", 64'(if8.lo), e.lo);
            end
        end
    end

    task automatic wait_idle32();
        int k = 0;
        while (if32.busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (if32.busy) begin
            n_checks++;
            $display("FAIL idle_timeout32: busy still 1 after %0d cycles", k);
        end
    endtask

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit push, output int unsigned s);
        exp_t        e;
        logic [63:0] h, l;
        wait_idle32();
        @(posedge clk); #1;
        if32.start = 1'b1;
        if32.op    = op;
        if32.src_a = a;
        if32.src_b = b;
        s = cyc;
        if (push) begin
            model(32, op, 64'(a), 64'(b), h, l);
            e.hi = h; e.lo = l; e.cyc = s;
            q32.push_back(e);
        end
        @(posedge clk); #1;
        if32.start = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        e;
        logic [63:0] h, l;
        int          k = 0;
        while (if8.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        if8.start = 1'b1;
        if8.op    = op;
        if8.src_a = a;
        if8.src_b = b;
        model(8, op, 64'(a), 64'(b), h, l);
        e.hi = h; e.lo = l; e.cyc = cyc;
        q8.push_back(e);
        @(posedge clk); #1;
        if8.start = 1'b0;
    endtask

    task automatic write_hilo32(input logic [31:0] h, input logic [31:0] l);
        wait_idle32();
        @(posedge clk); #1;
        if32.hi_we = 1'b1; if32.wdata = h;
        @(posedge clk); #1;
        if32.hi_we = 1'b0; if32.lo_we = 1'b1; if32.wdata = l;
        @(posedge clk); #1;
        if32.lo_we = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned s;
        int          n;
        {if32.start, if32.cancel, if32.hi_we, if32.lo_we} = '0;
        if32.op = '0; if32.src_a = '0; if32.src_b = '0; if32.wdata = '0;
        {if8.start, if8.cancel, if8.hi_we, if8.lo_we} = '0;
        if8.op = '0; if8.src_a = '0; if8.src_b = '0; if8.wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(if32.busy), 64'd0);
        check("rst_stall", 64'(if32.stall_req), 64'd0);
        check("rst_done", 64'(if32.done), 64'd0);
        check("rst_hi", 64'(if32.hi), 64'd0);
        check("rst_lo", 64'(if32.lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MULTU all-ones: stall covers the start cycle plus the 32 iterations.
        @(posedge clk); #1;
        if32.start = 1'b1; if32.op = 2'b01; if32.src_a = '1; if32.src_b = '1;
        q32.push_back('{hi: 64'hFFFF_FFFE, lo: 64'h0000_0001, cyc: cyc});
        @(negedge clk);
        check("stall_cycle0", 64'(if32.stall_req), 64'd1);
        @(posedge clk); #1;
        if32.start = 1'b0;
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!if32.stall_req) break;
            n++;
        end
        check("stall_cycles", 64'(n), 64'd33);

        issue32(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b1, s);
        issue32(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, s);
        issue32(2'b11, 32'd100, 32'd7, 1'b1, s);
        issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, s);
        issue32(2'b11, 32'd5, 32'd0, 1'b1, s);
        issue32(2'b10, 32'hFFFF_FF00, 32'd0, 1'b1, s);

        // MTHI/MTLO, then a MULT flushed mid-flight leaves HI/LO alone.
        write_hilo32(32'h1234, 32'h5678);
        @(negedge clk);
        check("mthi", 64'(if32.hi), 64'h1234);
        check("mtlo", 64'(if32.lo), 64'h5678);
        issue32(2'b00, 32'd9, 32'd9, 1'b0, s);
        while (cyc < s + 10) begin @(posedge clk); #1; end
        if32.cancel = 1'b1;
        @(posedge clk); #1;
        if32.cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 64'(if32.busy), 64'd0);
        check("cancel_stall", 64'(if32.stall_req), 64'd0);
        check("cancel_hi", 64'(if32.hi), 64'h1234);
        check("cancel_lo", 64'(if32.lo), 64'h5678);

        // Cancel landing on the DONE cycle: no done pulse, no commit.
        issue32(2'b01, 32'd6, 32'd7, 1'b0, s);
        while (cyc < s + 33) begin @(posedge clk); #1; end
        if32.cancel = 1'b1;
        @(negedge clk);
        check("done_cancel_busy", 64'(if32.busy), 64'd1);
        check("done_cancel_done", 64'(if32.done), 64'd0);
        @(posedge clk); #1;
        if32.cancel = 1'b0;
        @(negedge clk);
        check("done_cancel_hi", 64'(if32.hi), 64'h1234);
        check("done_cancel_lo", 64'(if32.lo), 64'h5678);

        // MTHI in the start cycle lands; a later MTHI while busy is dropped.
        wait_idle32();
        @(posedge clk); #1;
        if32.start = 1'b1; if32.op = 2'b01; if32.src_a = 32'd3; if32.src_b = 32'd5;
        if32.hi_we = 1'b1; if32.wdata = 32'hABCD;
        q32.push_back('{hi: 64'd0, lo: 64'd15, cyc: cyc});
        @(posedge clk); #1;
        if32.start = 1'b0; if32.hi_we = 1'b0;
        @(negedge clk);
        check("mthi_with_start", 64'(if32.hi), 64'hABCD);
        @(posedge clk); #1;
        if32.hi_we = 1'b1; if32.lo_we = 1'b1; if32.wdata = 32'hFFFF_0000;
        @(posedge clk); #1;
        if32.hi_we = 1'b0; if32.lo_we = 1'b0;
        @(negedge clk);
        check("mthi_busy_ignored", 64'(if32.hi), 64'hABCD);
        check("mtlo_busy_ignored", 64'(if32.lo), 64'h5678);

        // A second start during MUL is ignored.
        issue32(2'b00, 32'hFFFF_FFFE, 32'd1000, 1'b1, s);
        @(posedge clk); @(posedge clk); #1;
        if32.start = 1'b1; if32.op = 2'b11; if32.src_a = 32'd77; if32.src_b = 32'd3;
        @(posedge clk); #1;
        if32.start = 1'b0;

        for (int i = 0; i < 40; i++)
            issue32(2'($urandom_range(0, 3)), 32'(pick(32)), 32'(pick(32)), 1'b1, s);

        // Reset in cycle 5 of a DIV discards it and clears HI/LO.
        issue32(2'b10, 32'd1000, 32'd3, 1'b0, s);
        while (cyc < s + 5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy", 64'(if32.busy), 64'd0);
        check("rst_mid_stall", 64'(if32.stall_req), 64'd0);
        check("rst_mid_hi", 64'(if32.hi), 64'd0);
        check("rst_mid_lo", 64'(if32.lo), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue8(2'b01, 8'hFF, 8'hFF);
        issue8(2'b10, 8'h80, 8'hFF);
        issue8(2'b11, 8'd9, 8'd0);
        for (int i = 0; i < 20; i++)
            issue8(2'($urandom_range(0, 3)), 8'(pick(8)), 8'(pick(8)));

        wait_idle32();
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("q32_drained", 64'(q32.size()), 64'd0);
        check("q8_drained", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit attached to the EX stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU iteratively and owns the HI/LO register pair, including MTHI/MTLO writes.
- While an operation is in flight it raises a stall request into the pipeline stall controller.
- Generalises the single-cycle EX datapath with configurable width and multi-cycle sequencing.

Parameters:
- W, 32, operand width in bits; must be even and >= 4; HI and LO are each W bits.
- CNT_W, $clog2(W)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a mul/div instruction this cycle
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- src_a  in  W  rs operand (multiplicand / dividend)
- src_b  in  W  rt operand (multiplier / divisor)
- cancel  in  1  flush of the issuing instruction
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  W  MTHI/MTLO data
- stall_req  out  1  request EX-and-earlier stall
- busy  out  1  state is not IDLE
- done  out  1  result-commit cycle indicator
- hi  out  W  HI register
- lo  out  W  LO register

Behaviour:
- Reset: state IDLE; hi=0, lo=0; busy=0; done=0; stall_req=0; counter=0. Reset mid-operation discards the operation; HI/LO return to 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start=1: latch src_a, src_b and op; take operand magnitudes for signed ops; record the result signs; counter=0; go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: shift-add one multiplier bit per cycle into a 2W accumulator.
- DIV: restoring division, one quotient bit per cycle.
- In MUL or DIV, counter increments each cycle; when counter==W-1, go to DONE.
- DONE: done=1 for exactly one cycle. Apply sign correction. At the exit edge write {hi,lo}: product for MUL ops; hi=remainder, lo=quotient for DIV ops. Then go to IDLE.
- Timing: start sampled in cycle 0; MUL/DIV occupy cycles 1..W; DONE in cycle W+1; new hi/lo visible in cycle W+2.
- stall_req = (state==IDLE && start && !cancel) || state==MUL || state==DIV. It is low in DONE, so the issuing instruction leaves EX in cycle W+1 and a following MFHI sees the new value.
- busy = (state != IDLE).
- Signed multiply: full 2W-bit two's-complement product.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Overflow (-2^(W-1) / -1): lo = -2^(W-1), hi = 0. No exception.
- Divide by zero (any op): hi = src_a, lo = all ones, same latency. No exception.
- cancel: in MUL, DIV or DONE, return to IDLE next cycle with hi/lo unchanged and no done. In IDLE, cancel with start suppresses the start.
- start while busy is ignored.
- hi_we/lo_we take effect only in IDLE, on the next edge. If they coincide with start, the write lands and the operation still starts from the latched operands. They are ignored when not IDLE.

Test Plan:
- W=32, MULTU 0xFFFFFFFF*0xFFFFFFFF -> stall_req high cycles 0..32, done in cycle 33, then hi=0xFFFFFFFE, lo=0x00000001.
- MULT -7 * 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> hi=5, lo=0xFFFFFFFF, done in cycle 33.
- MTHI 0x1234 then MULT with cancel asserted in cycle 10 -> IDLE in cycle 11, no done pulse, hi=0x1234 and lo unchanged.
- start during MUL with different operands -> ignored; the first result commits correctly.
- Assert rst in cycle 5 of a DIV -> next cycle state IDLE, hi=lo=0, stall_req=0; W=8 build: MULTU 255*255 -> hi=0xFE, lo=0x01, done in cycle 9.
